iob_post_queue: RTL and testbench



---
 rtl/iob_pkg.sv | 23 ++
 rtl/iob_post_fifo.sv | 47 ++++
 rtl/iob_post_queue.sv | 133 +++++++++++++
 tb/tb_iob_post_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/iob_pkg.sv
// Shared types for the posted IO write queue: entry layout, master FSM states
// and the width helper for occupancy counters.
package iob_pkg;

    localparam int IOB_DEPTH = 4;
    localparam int IOB_AW    = 23;
    localparam int IOB_DW    = 16;

    typedef struct packed {
        logic [IOB_AW-1:0] addr;
        logic [IOB_DW-1:0] data;
        logic              u;
        logic              l;
    } iob_entry_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} iob_state_e;

    // Counter width able to hold 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/iob_post_fifo.sv
// Circular buffer of posted IO writes; the parent never pushes when full nor
// pops when empty, so no overflow guarding is done here.
module iob_post_fifo import iob_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  logic [W-1:0]              wdata_i,
    input  logic                      pop_i,
    output logic [W-1:0]              rdata_o,
    output logic [lvl_w(DEPTH)-1:0]   level_o,
    output logic                      full_o,
    output logic                      empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (pop_i)  rptr_q <= rptr_q + PW'(1);
            if (push_i && !pop_i)      level_q <= level_q + LW'(1);
            else if (pop_i && !push_i) level_q <= level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/iob_post_queue.sv
// Posted IO write queue between FSB decode and the IOB master: buffers postable
// writes and orders non-posted cycles strictly behind them.
module iob_post_queue import iob_pkg::*; #(
    parameter int DEPTH = IOB_DEPTH,
    parameter int AW    = IOB_AW,
    parameter int DW    = IOB_DW
) (
    input  logic                     FCLK,
    input  logic                     nRESin,
    input  logic                     BACT,
    input  logic                     IOCS,
    input  logic                     IOPWCS,
    input  logic                     nWE,
    input  logic                     nUDS,
    input  logic                     nLDS,
    input  logic [AW-1:0]            A,
    input  logic [DW-1:0]            D,
    output logic                     IOPWReady,
    output logic                     IONPReady,
    output logic                     BERRout,
    output logic                     IORDREQ,
    output logic                     IOWRREQ,
    output logic [AW-1:0]            IOA,
    output logic [DW-1:0]            IOD,
    output logic                     IOU,
    output logic                     IOL,
    input  logic                     IOACT,
    input  logic                     IODONE,
    input  logic                     IOBERR,
    output logic [lvl_w(DEPTH)-1:0]  Level,
    output logic                     Full,
    output logic                     Empty,
    output logic                     PWErr
);
    iob_state_e state_q, state_d;
    iob_entry_t wentry, head;
    logic       push, pop, np_req;
    logic       taken_q, np_q, rd_q, err_q, pwerr_q;
    logic [AW-1:0] ioa_q;
    logic [DW-1:0] iod_q;
    logic          iou_q, iol_q;

    assign np_req = BACT & IOCS & ~(IOPWCS & ~nWE);
    // Taken blocks a second push from the same FSB cycle while BACT stays high.
    assign push   = BACT & IOCS & IOPWCS & ~nWE & ~Full & ~taken_q;
    assign pop    = (state_q == WAIT) & IODONE & ~np_q;
    assign wentry = '{addr: A, data: D, u: ~nUDS, l: ~nLDS};

    iob_post_fifo #(.DEPTH(DEPTH), .W($bits(iob_entry_t))) u_fifo (
        .clk_i   (FCLK),
        .rst_ni  (nRESin),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (head),
        .level_o (Level),
        .full_o  (Full),
        .empty_o (Empty)
    );

    always_ff @(posedge FCLK or negedge nRESin) begin
        if (!nRESin) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!Empty || np_req) state_d = REQ;
            REQ:  if (IOACT)            state_d = WAIT;
            WAIT: if (IODONE)           state_d = DONE;
            DONE: if (!np_q || !BACT)   state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        IORDREQ   = (state_q == REQ) & rd_q;
        IOWRREQ   = (state_q == REQ) & ~rd_q;
        IONPReady = (state_q == DONE) & np_q & ~err_q;
        BERRout   = (state_q == DONE) & np_q & err_q;
    end

    // Request latch and completion status; queue entries win over a pending
    // non-posted cycle because the IDLE branch tests Empty first.
    always_ff @(posedge FCLK or negedge nRESin) begin
        if (!nRESin) begin
            taken_q <= 1'b0;
            np_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            pwerr_q <= 1'b0;
            ioa_q   <= '0;
            iod_q   <= '0;
            iou_q   <= 1'b0;
            iol_q   <= 1'b0;
        end else begin
            if (push)       taken_q <= 1'b1;
            else if (!BACT) taken_q <= 1'b0;

            if (state_q == IDLE) begin
                if (!Empty) begin
                    ioa_q <= head.addr;
                    iod_q <= head.data;
                    iou_q <= head.u;
                    iol_q <= head.l;
                    np_q  <= 1'b0;
                    rd_q  <= 1'b0;
                end else if (np_req) begin
                    ioa_q <= A;
                    iod_q <= D;
                    iou_q <= ~nUDS;
                    iol_q <= ~nLDS;
                    np_q  <= 1'b1;
                    rd_q  <= nWE;
                end
            end

            if (state_q == WAIT && IODONE) begin
                err_q <= IOBERR;
                if (!np_q && IOBERR) pwerr_q <= 1'b1;
            end
        end
    end

    assign IOPWReady = taken_q;
    assign IOA       = ioa_q;
    assign IOD       = iod_q;
    assign IOU       = iou_q;
    assign IOL       = iol_q;
    assign PWErr     = pwerr_q;

endmodule

// File: tb/tb_iob_post_queue.sv
// Randomized bench for iob_post_queue: FSB-side posts and non-posted cycles,
// a bench-driven IOB master, and a queue model of expected contents.
module tb_iob_post_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 23;
    localparam int DW    = 16;
    localparam int EW    = AW + DW + 2;

    logic FCLK = 1'b0, nRESin;
    logic BACT, IOCS, IOPWCS, nWE, nUDS, nLDS;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic IOPWReady, IONPReady, BERRout, IORDREQ, IOWRREQ, IOU, IOL;
    logic [AW-1:0] IOA;
    logic [DW-1:0] IOD;
    logic IOACT, IODONE, IOBERR;
    logic [2:0] Level;
    logic Full, Empty, PWErr;

    iob_post_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .FCLK(FCLK), .nRESin(nRESin), .BACT(BACT), .IOCS(IOCS), .IOPWCS(IOPWCS),
        .nWE(nWE), .nUDS(nUDS), .nLDS(nLDS), .A(A), .D(D),
        .IOPWReady(IOPWReady), .IONPReady(IONPReady), .BERRout(BERRout),
        .IORDREQ(IORDREQ), .IOWRREQ(IOWRREQ), .IOA(IOA), .IOD(IOD), .IOU(IOU), .IOL(IOL),
        .IOACT(IOACT), .IODONE(IODONE), .IOBERR(IOBERR),
        .Level(Level), .Full(Full), .Empty(Empty), .PWErr(PWErr)
    );

    always #5 FCLK = ~FCLK;

    int n_tests = 0, n_fail = 0;
    logic [EW-1:0] mq[$];
    bit pwerr_m = 0, chk_en = 0;
    logic [AW-1:0] np_a;
    logic [DW-1:0] np_d;
    logic np_u, np_l, np_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge FCLK);
        #1;
    endtask

    always @(negedge FCLK) begin
        if (chk_en) begin
            chk("level", Level, mq.size());
            chk("full", Full, mq.size() == DEPTH);
            chk("empty", Empty, mq.size() == 0);
            chk("pwerr", PWErr, pwerr_m);
        end
    end

    task automatic fsb_idle();
        BACT = 0; IOCS = 0; IOPWCS = 0; nWE = 1; nUDS = 1; nLDS = 1;
    endtask

    task automatic post_start(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic u, input logic l);
        BACT = 1; IOCS = 1; IOPWCS = 1; nWE = 0; A = a; D = d; nUDS = ~u; nLDS = ~l;
    endtask

    task automatic post(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic u, input logic l);
        post_start(a, d, u, l);
        tick();
        chk("pw_rdy", IOPWReady, 1);
        if (IOPWReady) mq.push_back({a, d, u, l});
        tick();
        chk("pw_hold", IOPWReady, 1);
        fsb_idle();
        tick();
        chk("pw_clr", IOPWReady, 0);
    endtask

    task automatic np_start(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic u, input logic l);
        BACT = 1; IOCS = 1; IOPWCS = rd ? 1'($urandom_range(0, 1)) : 1'b0; nWE = rd;
        A = a; D = d; nUDS = ~u; nLDS = ~l;
        np_a = a; np_d = d; np_u = u; np_l = l; np_rd = rd;
    endtask

    // Bench-side IOB master: waits for a request, acknowledges and completes it.
    task automatic m_serve(input bit be, input int act_dly, input int done_dly);
        int n = 0;
        bit isq;
        logic [EW-1:0] e;
        while (!(IOWRREQ || IORDREQ) && n < 40) begin tick(); n++; end
        if (n >= 40) begin chk("m_req_timeout", 0, 1); return; end
        isq = (mq.size() > 0);
        if (isq) begin
            e = mq[0];
            chk("q_iowr", IOWRREQ, 1);
            chk("q_iord", IORDREQ, 0);
            chk("q_ioa", IOA, e[EW-1 -: AW]);
            chk("q_iod", IOD, e[DW+1:2]);
            chk("q_iou", IOU, e[1]);
            chk("q_iol", IOL, e[0]);
        end else begin
            chk("np_iord", IORDREQ, np_rd);
            chk("np_iowr", IOWRREQ, !np_rd);
            chk("np_ioa", IOA, np_a);
            chk("np_iou", IOU, np_u);
            chk("np_iol", IOL, np_l);
            if (!np_rd) chk("np_iod", IOD, np_d);
        end
        for (int i = 0; i < act_dly; i++) begin
            tick();
            chk("req_hold", IOWRREQ | IORDREQ, 1);
        end
        IOACT = 1; tick(); IOACT = 0;
        chk("req_drop", IOWRREQ | IORDREQ, 0);
        for (int i = 0; i < done_dly; i++) tick();
        IODONE = 1; IOBERR = be; tick(); IODONE = 0; IOBERR = 0;
        if (isq) begin
            void'(mq.pop_front());
            if (be) pwerr_m = 1;
        end
    endtask

    task automatic np_cycle(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit be);
        np_start(rd, a, d, 1'b1, 1'b1);
        while (mq.size() > 0) m_serve($urandom_range(0, 7) == 0, $urandom_range(0, 2), $urandom_range(0, 2));
        m_serve(be, $urandom_range(0, 2), $urandom_range(0, 2));
        chk("np_rdy", IONPReady, !be);
        chk("np_berr", BERRout, be);
        tick();
        chk("np_rdy_hold", IONPReady, !be);
        chk("np_berr_hold", BERRout, be);
        fsb_idle();
        tick();
        chk("np_rdy_clr", IONPReady | BERRout, 0);
        chk("np_no_reissue", IORDREQ | IOWRREQ, 0);
    endtask

    initial begin
        int lat;
        nRESin = 0; IOACT = 0; IODONE = 0; IOBERR = 0; A = '0; D = '0;
        fsb_idle();
        #12;
        chk("rst_level", Level, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_full", Full, 0);
        chk("rst_outs", {IOPWReady, IONPReady, BERRout, IORDREQ, IOWRREQ, PWErr}, 0);
        nRESin = 1;
        tick();
        chk_en = 1;

        // Single posted write and its IOWRREQ latency.
        post_start(23'h580000, 16'hA5A5, 1, 1);
        tick();
        chk("t1_pwrdy", IOPWReady, 1);
        mq.push_back({23'h580000, 16'hA5A5, 1'b1, 1'b1});
        chk("t1_wr_early", IOWRREQ, 0);
        tick();
        chk("t1_wr", IOWRREQ, 1);
        chk("t1_ioa", IOA, 23'h580000);
        chk("t1_iod", IOD, 16'hA5A5);
        fsb_idle();
        tick();
        chk("t1_pwclr", IOPWReady, 0);
        m_serve(0, 1, 1);
        chk("t1_level0", Level, 0);

        // Stalled master: fill to DEPTH, fifth write waits for a pop.
        for (int i = 0; i < DEPTH; i++) post(AW'(23'h100 + i), DW'($urandom), 1, i[0]);
        chk("t2_full", Full, 1);
        post_start(23'h7FFF0, 16'h5555, 0, 1);
        for (int i = 0; i < 3; i++) begin tick(); chk("t2_pw_wait", IOPWReady, 0); end
        m_serve(0, 0, 0);
        lat = 0;
        while (!IOPWReady && lat < 5) begin tick(); lat++; end
        chk("t2_pw_lat", lat, 1);
        mq.push_back({23'h7FFF0, 16'h5555, 1'b0, 1'b1});
        chk("t2_level4", Level, 4);
        fsb_idle();
        tick();
        while (mq.size() > 0) m_serve(0, 0, 1);

        // Read behind three queued writes; then posted and non-posted errors.
        for (int i = 0; i < 3; i++) post(AW'($urandom), DW'($urandom), 1, 1);
        np_cycle(1, 23'h2A0000, 16'h0, 0);
        post(23'h11, 16'h1111, 1, 0);
        post(23'h22, 16'h2222, 0, 1);
        m_serve(1, 0, 0);
        chk("t4_pwerr", PWErr, 1);
        post(23'h33, 16'h3333, 1, 1);
        while (mq.size() > 0) m_serve(0, 1, 0);
        chk("t4_pwerr_sticky", PWErr, 1);
        np_cycle(0, 23'h3C0002, 16'hBEEF, 1);

        // Randomized mix of posts, drains and non-posted cycles.
        for (int it = 0; it < 60; it++) begin
            int r = $urandom_range(0, 9);
            if (r < 5 && mq.size() < DEPTH)
                post(AW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
            else if (r < 8 && mq.size() > 0)
                m_serve($urandom_range(0, 7) == 0, $urandom_range(0, 2), $urandom_range(0, 2));
            else
                np_cycle(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 3) == 0);
        end

        // Asynchronous reset with entries queued and a request up.
        while (mq.size() > 0) m_serve(0, 0, 0);
        for (int i = 0; i < 3; i++) post(AW'($urandom), DW'($urandom), 1, 1);
        chk("t6_req_up", IOWRREQ, 1);
        chk_en = 0;
        #2 nRESin = 0;
        #1;
        mq.delete();
        pwerr_m = 0;
        chk("t6_wr_drop", IOWRREQ, 0);
        chk("t6_level", Level, 0);
        chk("t6_empty", Empty, 1);
        chk("t6_pwerr", PWErr, 0);
        @(negedge FCLK);
        #1 nRESin = 1;
        tick();
        IODONE = 1; IOBERR = 1;
        tick();
        IODONE = 0; IOBERR = 0;
        chk("t6_late_level", Level, 0);
        chk("t6_late_rdy", IONPReady | BERRout, 0);
        chk("t6_late_req", IOWRREQ | IORDREQ, 0);
        chk_en = 1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
